// File: rtl/fx3_sf_pkg.sv
// Shared types for the FX3 slave-FIFO write controller: FSM states and socket addresses.
package fx3_sf_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        WRITE    = 2'd2,
        COMMIT   = 2'd3
    } fx3_sf_state_e;

    localparam logic [1:0] SOCKET_P0 = 2'b00;
    localparam logic [1:0] SOCKET_P1 = 2'b01;
    localparam logic [1:0] SOCKET_P2 = 2'b10;
    localparam logic [1:0] SOCKET_P3 = 2'b11;

endpackage

// File: rtl/fx3_sf_idle_timer.sv
// Idle-cycle counter for partial packets; tick asserts once IDLE_TO-1 idle cycles have elapsed.
module fx3_sf_idle_timer #(
    parameter int IDLE_TO = 256
) (
    input  logic PCLK,
    input  logic RESET_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int TW = $clog2(IDLE_TO + 1);

    logic [TW-1:0] count;

    always_ff @(posedge PCLK) begin
        if (!RESET_n || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == TW'(IDLE_TO - 1));

endmodule

// File: rtl/fx3_slave_fifo_write_ctrl.sv
// FX3 GPIF-II synchronous slave FIFO write master: paces source words onto DQ and
// commits full buffers implicitly and partial buffers with a PKTEND_n strobe.
module fx3_slave_fifo_write_ctrl
    import fx3_sf_pkg::*;
#(
    parameter int         DATA_W      = 32,
    parameter int         BURST_LEN   = 1024,
    parameter int         IDLE_TO     = 256,
    parameter logic [1:0] SOCKET_ADDR = SOCKET_P0
) (
    input  logic              PCLK,
    input  logic              RESET_n,
    input  logic              en,
    input  logic              flush,
    input  logic [DATA_W-1:0] src_data,
    input  logic              src_valid,
    output logic              src_ready,
    input  logic              FLAGA,
    input  logic              FLAGB,
    output logic              SLCS_n,
    output logic              SLWR_n,
    output logic              SLRD_n,
    output logic              SLOE_n,
    output logic              PKTEND_n,
    output logic [1:0]        A,
    output logic [DATA_W-1:0] DQ,
    output logic              busy,
    output logic [15:0]       pkt_cnt
);

    localparam int              CNT_W     = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(BURST_LEN);

    fx3_sf_state_e     state, state_nxt;
    logic [CNT_W-1:0]  word_cnt;
    logic              commit_pend;
    logic              accept, last_word, has_data, commit_req;
    logic              timer_clear, timer_en, timer_tick;
    logic              slcs_n_d, slwr_n_d, pktend_n_d;
    logic [DATA_W-1:0] dq_d;

    // A commit request that lands on an accept is held for one cycle so the word goes out first.
    assign src_ready  = (state == WRITE) & en & FLAGB & (word_cnt < FULL_CNT) & ~commit_pend;
    assign accept     = src_valid & src_ready;
    assign last_word  = (word_cnt == LAST_WORD);
    assign has_data   = (word_cnt != '0);
    assign commit_req = commit_pend | (has_data & (timer_tick | flush | ~en));

    assign busy   = (state != IDLE);
    assign SLRD_n = 1'b1;
    assign SLOE_n = 1'b1;
    assign A      = SOCKET_ADDR;

    assign timer_clear = accept | (state_nxt != WRITE);
    assign timer_en    = (state == WRITE) & has_data;

    fx3_sf_idle_timer #(
        .IDLE_TO (IDLE_TO)
    ) u_idle_timer (
        .PCLK    (PCLK),
        .RESET_n (RESET_n),
        .clear   (timer_clear),
        .enable  (timer_en),
        .tick    (timer_tick)
    );

    always_ff @(posedge PCLK) begin
        if (!RESET_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (en) state_nxt = WAIT_RDY;
            end
            WAIT_RDY: begin
                if (!en)       state_nxt = IDLE;
                else if (FLAGA) state_nxt = WRITE;
            end
            WRITE: begin
                // A full buffer commits itself; a coincident flush is dropped.
                if (accept && last_word)       state_nxt = WAIT_RDY;
                else if (accept)               state_nxt = WRITE;
                else if (commit_req)           state_nxt = COMMIT;
                else if (!has_data && !en)     state_nxt = IDLE;
            end
            COMMIT: begin
                state_nxt = en ? WAIT_RDY : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        slcs_n_d   = (state_nxt == IDLE);
        slwr_n_d   = ~accept;
        pktend_n_d = (state_nxt != COMMIT);
        dq_d       = accept ? src_data : DQ;
    end

    always_ff @(posedge PCLK) begin
        if (!RESET_n) begin
            SLCS_n      <= 1'b1;
            SLWR_n      <= 1'b1;
            PKTEND_n    <= 1'b1;
            DQ          <= '0;
            word_cnt    <= '0;
            commit_pend <= 1'b0;
            pkt_cnt     <= '0;
        end else begin
            SLCS_n      <= slcs_n_d;
            SLWR_n      <= slwr_n_d;
            PKTEND_n    <= pktend_n_d;
            DQ          <= dq_d;
            commit_pend <= accept & ~last_word & commit_req;
            if (accept && last_word) begin
                word_cnt <= '0;
            end else if (accept) begin
                word_cnt <= word_cnt + 1'b1;
            end else if (state == COMMIT) begin
                word_cnt <= '0;
            end
            if ((accept && last_word) || (state == COMMIT)) begin
                pkt_cnt <= pkt_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fx3_slave_fifo_write_ctrl.sv
// Directed scenarios plus randomized traffic against a packet-level model of the FX3 write master.
module tb_fx3_slave_fifo_write_ctrl;

    localparam int DATA_W = 32;
    localparam int BL     = 8;
    localparam int ITO    = 16;

    logic              PCLK = 1'b0;
    logic              RESET_n, en, flush, src_valid, FLAGA, FLAGB;
    logic [DATA_W-1:0] src_data;
    logic              src_ready, SLCS_n, SLWR_n, SLRD_n, SLOE_n, PKTEND_n, busy;
    logic [1:0]        A;
    logic [DATA_W-1:0] DQ;
    logic [15:0]       pkt_cnt;

    fx3_slave_fifo_write_ctrl #(
        .DATA_W      (DATA_W),
        .BURST_LEN   (BL),
        .IDLE_TO     (ITO),
        .SOCKET_ADDR (2'b00)
    ) dut (
        .PCLK      (PCLK),
        .RESET_n   (RESET_n),
        .en        (en),
        .flush     (flush),
        .src_data  (src_data),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .FLAGA     (FLAGA),
        .FLAGB     (FLAGB),
        .SLCS_n    (SLCS_n),
        .SLWR_n    (SLWR_n),
        .SLRD_n    (SLRD_n),
        .SLOE_n    (SLOE_n),
        .PKTEND_n  (PKTEND_n),
        .A         (A),
        .DQ        (DQ),
        .busy      (busy),
        .pkt_cnt   (pkt_cnt)
    );

    always #5 PCLK = ~PCLK;

    int n_chk  = 0;
    int n_pass = 0;

    // Model view: 0 idle, 1 waiting for a buffer, 2 streaming, 3 committing a short packet.
    int                m_ph, m_words, m_step, m_last_acc;
    bit                m_known = 1'b0;
    bit                m_pend;
    logic [DATA_W-1:0] m_dq;
    logic              m_slwr_n;
    logic [15:0]       m_pkt;

    int                cyc = 0, seq = 0, nacc = 0, last_acc = 0;
    int                n_wr = 0, n_pe = 0, pe_cyc = -1;
    logic              pe_slwr = 1'b1;
    logic [DATA_W-1:0] wr_log[$];
    bit                took;

    int b_wr, b_pe, b_seq, b_acc, k;
    logic [15:0] b_pkt;

    function automatic logic [DATA_W-1:0] pattern(input int s);
        return 32'h5A00_0000 + 32'(s);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    task automatic model_cycle();
        bit rdy, acc, req, last;
        if (m_known) begin
            chk("SLCS_n",   SLCS_n,   m_ph == 0);
            chk("SLWR_n",   SLWR_n,   m_slwr_n);
            chk("PKTEND_n", PKTEND_n, m_ph != 3);
            chk("DQ",       DQ,       m_dq);
            chk("pkt_cnt",  pkt_cnt,  m_pkt);
            chk("busy",     busy,     m_ph != 0);
            chk("fixed_pins", {SLRD_n, SLOE_n, A}, 4'b1100);
            if (SLWR_n === 1'b0) begin
                n_wr++;
                wr_log.push_back(DQ);
            end
            if (PKTEND_n === 1'b0) begin
                n_pe++;
                pe_cyc  = cyc;
                pe_slwr = SLWR_n;
            end
        end
        rdy = (m_ph == 2) && (en === 1'b1) && (FLAGB === 1'b1) && (m_words < BL) && !m_pend;
        if (m_known) chk("src_ready", src_ready, rdy);
        acc = rdy && (src_valid === 1'b1);
        m_step++;
        if (RESET_n !== 1'b1) begin
            m_ph = 0; m_pend = 0; m_words = 0; m_dq = '0; m_slwr_n = 1'b1;
            m_pkt = '0; m_last_acc = m_step; m_known = 1'b1;
        end else if (m_known) begin
            last = acc && (m_words == BL - 1);
            req  = m_pend || ((m_words > 0) &&
                   ((m_step - m_last_acc) == ITO || flush === 1'b1 || en !== 1'b1));
            m_slwr_n = !acc;
            if (acc) m_dq = src_data;
            m_pend = 1'b0;
            case (m_ph)
                0: if (en) m_ph = 1;
                1: if (!en) m_ph = 0; else if (FLAGA) m_ph = 2;
                2: begin
                    if (last) begin m_ph = 1; m_words = 0; m_pkt++; end
                    else if (acc) begin m_words++; m_pend = req; end
                    else if (req) m_ph = 3;
                    else if (m_words == 0 && !en) m_ph = 0;
                end
                default: begin m_words = 0; m_pkt++; m_ph = en ? 1 : 0; end
            endcase
            if (acc) m_last_acc = m_step;
        end
    endtask

    task automatic step();
        @(negedge PCLK);
        model_cycle();
        took = (src_valid === 1'b1) && (src_ready === 1'b1);
        @(posedge PCLK);
        #1;
        cyc++;
        if (took) begin
            nacc++;
            last_acc = cyc;
            seq++;
        end
        src_data = pattern(seq);
        flush = 1'b0;
    endtask

    task automatic snap();
        b_wr = n_wr; b_pe = n_pe; b_seq = seq; b_acc = nacc; b_pkt = pkt_cnt;
    endtask

    task automatic wait_acc(input int n, input string nm);
        int j = 0;
        while ((nacc - b_acc) < n && j < 200) begin step(); j++; end
        chk(nm, nacc - b_acc, n);
    endtask

    task automatic wait_pkt(input logic [15:0] target, input string nm);
        int j = 0;
        while (pkt_cnt !== target && j < 200) begin step(); j++; end
        chk(nm, pkt_cnt, target);
    endtask

    initial begin
        RESET_n = 1'b0; en = 1'b0; flush = 1'b0; src_valid = 1'b0;
        FLAGA = 1'b0; FLAGB = 1'b1; src_data = pattern(0);
        repeat (3) step();
        chk("rst_SLCS_n", SLCS_n, 1'b1);
        chk("rst_DQ", DQ, 0);
        chk("rst_pkt_cnt", pkt_cnt, 0);
        chk("rst_busy", busy, 1'b0);

        // Full burst of BL words with no short-packet strobe.
        RESET_n = 1'b1; en = 1'b1; FLAGA = 1'b1; src_valid = 1'b1;
        snap();
        k = 0;
        while (n_wr == b_wr && k < 50) begin step(); k++; end
        FLAGA = 1'b0;
        wait_pkt(16'd1, "t1_pkt_done");
        repeat (3) step();
        chk("t1_writes", n_wr - b_wr, BL);
        chk("t1_pktend", n_pe - b_pe, 0);
        for (int i = 0; i < BL; i++) chk("t1_word", wr_log[b_wr + i], pattern(b_seq + i));
        chk("t1_wait_slcs", SLCS_n, 1'b0);
        chk("t1_busy", busy, 1'b1);

        // FLAGB stall after the third accept.
        snap();
        FLAGA = 1'b1;
        wait_acc(3, "t2_three_acc");
        FLAGA = 1'b0; FLAGB = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_stall_ready", src_ready, 1'b0);
            step();
        end
        chk("t2_no_acc_in_stall", nacc - b_acc, 3);
        FLAGB = 1'b1;
        step();
        chk("t2_w4_strobe", SLWR_n, 1'b0);
        chk("t2_w4_data", DQ, pattern(b_seq + 3));
        wait_pkt(b_pkt + 16'd1, "t2_pkt_done");
        repeat (3) step();
        chk("t2_writes", n_wr - b_wr, BL);
        for (int i = 0; i < BL; i++) chk("t2_word", wr_log[b_wr + i], pattern(b_seq + i));

        // Idle timeout commits a 3-word short packet.
        snap();
        FLAGA = 1'b1;
        wait_acc(3, "t3_three_acc");
        src_valid = 1'b0; FLAGA = 1'b0;
        k = 0;
        while (n_pe == b_pe && k < 60) begin step(); k++; end
        repeat (2) step();
        chk("t3_pktend_count", n_pe - b_pe, 1);
        chk("t3_timeout_delay", pe_cyc - last_acc, ITO);
        chk("t3_slwr_at_pktend", pe_slwr, 1'b1);
        chk("t3_pkt_cnt", pkt_cnt, b_pkt + 16'd1);
        chk("t3_writes", n_wr - b_wr, 3);

        // Flush at five words, then a flush with nothing buffered.
        snap();
        FLAGA = 1'b1; src_valid = 1'b1;
        wait_acc(5, "t4_five_acc");
        src_valid = 1'b0; FLAGA = 1'b0; flush = 1'b1;
        step();
        chk("t4_pktend_low", PKTEND_n, 1'b0);
        chk("t4_slwr_high", SLWR_n, 1'b1);
        step();
        chk("t4_pktend_release", PKTEND_n, 1'b1);
        chk("t4_pkt_cnt", pkt_cnt, b_pkt + 16'd1);
        chk("t4_writes", n_wr - b_wr, 5);
        snap();
        FLAGA = 1'b1;
        repeat (3) step();
        FLAGA = 1'b0; flush = 1'b1;
        step();
        repeat (20) step();
        chk("t4_zlp_pktend", n_pe - b_pe, 0);
        chk("t4_zlp_pkt_cnt", pkt_cnt, b_pkt);

        // Reset in the middle of a packet.
        snap();
        FLAGA = 1'b1; src_valid = 1'b1;
        wait_acc(4, "t5_four_acc");
        src_valid = 1'b0; FLAGA = 1'b0; RESET_n = 1'b0;
        step();
        chk("t5_strobes", {SLCS_n, SLWR_n, PKTEND_n}, 3'b111);
        chk("t5_DQ", DQ, 0);
        chk("t5_pkt_cnt", pkt_cnt, 0);
        chk("t5_busy", busy, 1'b0);
        RESET_n = 1'b1;

        // Last word of a buffer coincident with flush.
        snap();
        FLAGA = 1'b1; src_valid = 1'b1;
        wait_acc(BL - 1, "t6_acc");
        flush = 1'b1; FLAGA = 1'b0;
        step();
        src_valid = 1'b0;
        repeat (20) step();
        chk("t6_pktend", n_pe - b_pe, 0);
        chk("t6_pkt_cnt", pkt_cnt, 16'd1);
        chk("t6_writes", n_wr - b_wr, BL);

        // Randomized traffic: alternating dense and sparse source phases.
        for (int c = 0; c < 2500; c++) begin
            bit sparse;
            sparse    = ((c / 64) % 2) == 1;
            RESET_n   = ($urandom_range(0, 299) != 0);
            en        = ($urandom_range(0, 15) != 0);
            flush     = ($urandom_range(0, 24) == 0);
            src_valid = sparse ? ($urandom_range(0, 23) == 0) : ($urandom_range(0, 3) != 0);
            FLAGA     = ($urandom_range(0, 2) != 0);
            FLAGB     = ($urandom_range(0, 4) != 0);
            step();
        end
        src_valid = 1'b0;
        repeat (4) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
